kbd_mmio: RTL and testbench

PS/2 keyboard receiver with a scan-code FIFO, exposed as a two-word read-only memory-mapped responder for the CPU's keyboard region (0xe0000000). It samples the asynchronous PS/2 clock/data lines, deframes 11-bit frames, and queues valid scan codes. The CPU-side address decoder drives one-cycle read strobes into it and muxes its registered `rd_data` onto `dmem_data_out`.

---
 rtl/kbd_mmio.sv | 196 +++++++++++++++++++
 tb/tb_kbd_mmio.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/kbd_mmio.sv
// PS/2 keyboard receiver with a scan-code FIFO, read through a two-word
// memory-mapped window: word 0 pops a byte, word 1 reports/clears status.
module kbd_mmio #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_CYCLES  = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    input  logic        rd_addr,
    output logic [31:0] rd_data,
    output logic        kbd_nonempty
);

    localparam int L     = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << L;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ---------------- input synchronizers and clock filter ----------------
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FILT_LAST) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        fall = filt_q & ~filt_d;
    end

    // ---------------- frame receiver ----------------
    state_t        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_q, push_d;
    logic [7:0]    pbyte_q, pbyte_d;
    logic          err_set;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = '0;
        push_d  = 1'b0;
        pbyte_d = pbyte_q;
        err_set = 1'b0;
        if (state_q != S_IDLE && !fall) begin
            if (tmo_q == TMO_LAST) begin
                // Keyboard went quiet mid-frame: abandon the partial byte.
                state_d = S_IDLE;
                err_set = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
        if (fall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
                S_DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (dat_s2_q && (^shift_q ^ par_q)) begin
                        push_d  = 1'b1;
                        pbyte_d = shift_q;
                    end else begin
                        err_set = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FIFO and register interface ----------------
    logic [7:0]  mem_q [DEPTH];
    logic [L-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [L:0]  cnt_q, cnt_d;
    logic        err_q, err_d, ovf_q, ovf_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        nonempty, full, pop, wr, ovf_set, clr;

    always_comb begin
        nonempty  = (cnt_q != '0);
        full      = cnt_q[L];
        pop       = rd_en & ~rd_addr & nonempty;
        // A pop in the same cycle frees the slot the push needs.
        wr        = push_q & (~full | pop);
        ovf_set   = push_q & full & ~pop;
        clr       = rd_en & rd_addr;
        wptr_d    = wr  ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d     = cnt_q;
        if (wr && !pop) cnt_d = cnt_q + 1'b1;
        if (pop && !wr) cnt_d = cnt_q - 1'b1;
        err_d     = err_set | (err_q & ~clr);
        ovf_d     = ovf_set | (ovf_q & ~clr);
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (rd_addr) begin
                rd_data_d = {16'h0, 8'(cnt_q), 4'h0, err_q, ovf_q, full, nonempty};
            end else if (nonempty) begin
                rd_data_d = {23'h0, 1'b1, mem_q[rptr_q]};
            end else begin
                rd_data_d = 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= pbyte_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            state_q   <= S_IDLE;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            push_q    <= 1'b0;
            pbyte_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= ps2_data;
            dat_s2_q  <= dat_s1_q;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            state_q   <= state_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            push_q    <= push_d;
            pbyte_q   <= pbyte_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign kbd_nonempty = (cnt_q != '0);

endmodule

// File: tb/tb_kbd_mmio.sv
// Directed bench for kbd_mmio: PS/2 frames are bit-banged on the pins and
// results are read back through the register window.
module tb_kbd_mmio;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        rd_en = 1'b0;
    logic        rd_addr = 1'b0;
    logic [31:0] rd_data;
    logic        kbd_nonempty;

    int n_vec = 0;
    int n_err = 0;

    kbd_mmio #(.FIFO_DEPTH_LOG2(4), .FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .kbd_nonempty(kbd_nonempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Start, data LSB first, parity; stop bit left to the caller.
    task automatic send_head(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_head(b, bad_par);
        send_bit(1'b1);
        repeat (5) @(negedge clk);
    endtask

    task automatic rd(input logic a, output logic [31:0] d);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en   = 1'b0;
        d       = rd_data;
    endtask

    // Sends a frame whose push lands in the same cycle as a data-read strobe:
    // sync (2) + filter (8) cycles after the stop-bit pin edge, push one later.
    task automatic push_collide(input logic [7:0] b, output logic [31:0] d);
        send_head(b, 1'b0);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = 1'b0;
        @(negedge clk);
        rd_en   = 1'b0;
        d       = rd_data;
        repeat (HALF - 11) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_nonempty", {31'h0, kbd_nonempty}, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // single good frame
        send_frame(8'h1C, 1'b0);
        rd(1'b1, d); chk("good_status", d, 32'h0000_0101);
        chk("good_nonempty", {31'h0, kbd_nonempty}, 32'h1);
        rd(1'b0, d); chk("good_data", d, 32'h0000_011C);
        rd(1'b1, d); chk("good_status_after", d, 32'h0);
        chk("good_nonempty_after", {31'h0, kbd_nonempty}, 32'h0);

        // parity error
        send_frame(8'h1C, 1'b1);
        rd(1'b1, d); chk("par_status", d, 32'h0000_0008);
        rd(1'b1, d); chk("par_status_clr", d, 32'h0);

        // overflow: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0);
        rd(1'b1, d); chk("ovf_status", d, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            rd(1'b0, d); chk($sformatf("drain_%0d", i), d, 32'h100 + i);
        end
        rd(1'b0, d); chk("drain_empty", d, 32'h0);
        rd(1'b1, d); chk("drain_status", d, 32'h0);

        // short glitch while idle is filtered out
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        rd(1'b1, d); chk("glitch_status", d, 32'h0);

        // partial frame then timeout
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TIMEOUT + 10) @(negedge clk);
        rd(1'b1, d); chk("timeout_status", d, 32'h0000_0008);
        send_frame(8'hF0, 1'b0);
        rd(1'b0, d); chk("after_timeout_data", d, 32'h0000_01F0);
        rd(1'b0, d); chk("after_timeout_empty", d, 32'h0);

        // read strobe in the push cycle on an empty FIFO
        push_collide(8'h5A, d); chk("collide_empty_rd", d, 32'h0);
        rd(1'b0, d); chk("collide_next_rd", d, 32'h0000_015A);

        // full FIFO, pop during push keeps count and no overflow
        for (int i = 0; i < 16; i++) send_frame(8'h30 + 8'(i), 1'b0);
        push_collide(8'h40, d); chk("collide_full_rd", d, 32'h0000_0130);
        rd(1'b1, d); chk("collide_full_status", d, 32'h0000_1003);
        rd(1'b0, d); chk("collide_full_next", d, 32'h0000_0131);

        // reset mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_rd_data", rd_data, 32'h0);
        chk("midrst_nonempty", {31'h0, kbd_nonempty}, 32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h29, 1'b0);
        rd(1'b0, d); chk("midrst_data", d, 32'h0000_0129);
        rd(1'b0, d); chk("midrst_empty", d, 32'h0);
        rd(1'b1, d); chk("midrst_status", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
